// File: rtl/abacus_pkg.sv
// rtl/abacus_pkg.sv - shared types and register map for the ABACUS snapshot reader
package abacus_pkg;

   // ABACUS register map as seen from the Wishbone initiator
   localparam logic [31:0] ABACUS_BASE_ADDR  = 32'hF003_0000;
   localparam logic [31:0] ABACUS_IPROF_BASE = ABACUS_BASE_ADDR + 32'h0000_0100;
   localparam logic [31:0] ABACUS_CPROF_BASE = ABACUS_BASE_ADDR + 32'h0000_0200;

   // Largest snapshot the beat index field can describe
   localparam int ABACUS_SNAP_MAX_WORDS = 64;
   localparam int ABACUS_SNAP_IDX_W     = $clog2(ABACUS_SNAP_MAX_WORDS);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_REQ,
      ST_GAP,
      ST_FINISH
   } abacus_snap_state_e;

   typedef struct packed {
      logic [31:0]                  data;
      logic [ABACUS_SNAP_IDX_W-1:0] index;
      logic                         last;
   } abacus_snapshot_beat_t;

endpackage

// File: rtl/abacus_snapshot_fifo.sv
// rtl/abacus_snapshot_fifo.sv - small synchronous FIFO of snapshot beats
module abacus_snapshot_fifo
   import abacus_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  push,
   input  abacus_snapshot_beat_t push_beat,
   input  logic                  pop,
   output abacus_snapshot_beat_t head_beat,
   output logic                  full,
   output logic                  empty
);

   localparam int PTR_W = $clog2(DEPTH);

   abacus_snapshot_beat_t mem_q [DEPTH];
   logic [PTR_W-1:0]      wr_ptr_q;
   logic [PTR_W-1:0]      rd_ptr_q;
   logic [PTR_W:0]        count_q;
   logic                  do_push;
   logic                  do_pop;

   assign full      = (count_q == (PTR_W+1)'(DEPTH));
   assign empty     = (count_q == '0);
   assign do_pop    = pop & ~empty;
   // A pop in the same cycle frees the slot, so a push into a full FIFO is legal then
   assign do_push   = push & (~full | do_pop);
   assign head_beat = mem_q[rd_ptr_q];

   // Storage, pointers (wrap naturally at power-of-two depth) and occupancy
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) begin
            mem_q[wr_ptr_q] <= push_beat;
            wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
         end
         if (do_pop) begin
            rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         end
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + (PTR_W+1)'(1);
            2'b01:   count_q <= count_q - (PTR_W+1)'(1);
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: rtl/abacus_snapshot_reader.sv
// rtl/abacus_snapshot_reader.sv - Wishbone block reader streaming ABACUS registers out
module abacus_snapshot_reader
   import abacus_pkg::*;
#(
   parameter  int MAX_WORDS      = 64,
   parameter  int TIMEOUT_CYCLES = 16,
   parameter  int FIFO_DEPTH     = 2,
   localparam int CNT_W          = $clog2(MAX_WORDS + 1),
   localparam int IDX_W          = $clog2(MAX_WORDS)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [31:0]      base_addr,
   input  logic [CNT_W-1:0] word_count,
   output logic             busy,
   output logic             done,
   output logic             timeout_err,
   output logic             wb_cyc,
   output logic             wb_stb,
   output logic             wb_we,
   output logic [31:0]      wb_adr,
   output logic [31:0]      wb_dat_o,
   input  logic [31:0]      wb_dat_i,
   input  logic             wb_ack,
   output logic             m_valid,
   input  logic             m_ready,
   output logic [31:0]      m_data,
   output logic [IDX_W-1:0] m_index,
   output logic             m_last
);

   localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);

   abacus_snap_state_e    state_q;
   logic [31:0]           addr_q;
   logic [31:0]           adr_q;
   logic [CNT_W-1:0]      rem_q;
   logic [IDX_W-1:0]      idx_q;
   logic [WAIT_W-1:0]     wait_q;
   logic                  busy_q;
   logic                  done_q;
   logic                  terr_q;
   logic                  cyc_q;

   logic [CNT_W-1:0]      count_d;
   logic [31:0]           addr_d;
   logic                  ack_hit;
   logic                  fifo_full;
   logic                  fifo_empty;
   abacus_snapshot_beat_t push_beat;
   abacus_snapshot_beat_t head_beat;

   assign count_d = (word_count > CNT_W'(MAX_WORDS)) ? CNT_W'(MAX_WORDS) : word_count;
   assign addr_d  = base_addr & ~32'h0000_0003;
   // Acks outside REQ are stale and must never reach the FIFO
   assign ack_hit = (state_q == ST_REQ) & wb_ack;

   assign push_beat.data  = wb_dat_i;
   assign push_beat.index = ABACUS_SNAP_IDX_W'(idx_q);
   assign push_beat.last  = (rem_q == CNT_W'(1));

   abacus_snapshot_fifo #(
      .DEPTH(FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (ack_hit),
      .push_beat (push_beat),
      .pop       (m_ready),
      .head_beat (head_beat),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   assign busy        = busy_q;
   assign done        = done_q;
   assign timeout_err = terr_q;
   assign wb_cyc      = cyc_q;
   assign wb_stb      = cyc_q;
   assign wb_we       = 1'b0;
   assign wb_adr      = adr_q;
   assign wb_dat_o    = 32'h0;
   assign m_valid     = ~fifo_empty;
   assign m_data      = head_beat.data;
   assign m_index     = IDX_W'(head_beat.index);
   assign m_last      = head_beat.last;

   // Snapshot sequencer; bus controls are registered so cyc/stb drop on the ack edge
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         addr_q  <= '0;
         adr_q   <= '0;
         rem_q   <= '0;
         idx_q   <= '0;
         wait_q  <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         terr_q  <= 1'b0;
         cyc_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  busy_q <= 1'b1;
                  terr_q <= 1'b0;
                  if (count_d == '0) begin
                     state_q <= ST_FINISH;
                     done_q  <= 1'b1;
                  end else begin
                     addr_q <= addr_d;
                     rem_q  <= count_d;
                     idx_q  <= '0;
                     wait_q <= '0;
                     // Beats of the previous snapshot may still be draining
                     if (!fifo_full) begin
                        state_q <= ST_REQ;
                        cyc_q   <= 1'b1;
                        adr_q   <= addr_d;
                     end else begin
                        state_q <= ST_GAP;
                     end
                  end
               end
            end
            ST_REQ: begin
               if (wb_ack) begin
                  cyc_q  <= 1'b0;
                  adr_q  <= '0;
                  addr_q <= addr_q + 32'd4;
                  idx_q  <= idx_q + IDX_W'(1);
                  rem_q  <= rem_q - CNT_W'(1);
                  if (rem_q == CNT_W'(1)) begin
                     state_q <= ST_FINISH;
                     done_q  <= 1'b1;
                  end else begin
                     state_q <= ST_GAP;
                  end
               end else if (wait_q == WAIT_W'(TIMEOUT_CYCLES - 1)) begin
                  cyc_q   <= 1'b0;
                  adr_q   <= '0;
                  terr_q  <= 1'b1;
                  state_q <= ST_FINISH;
                  done_q  <= 1'b1;
               end else begin
                  wait_q <= wait_q + WAIT_W'(1);
               end
            end
            ST_GAP: begin
               if (!fifo_full) begin
                  state_q <= ST_REQ;
                  cyc_q   <= 1'b1;
                  adr_q   <= addr_q;
                  wait_q  <= '0;
               end
            end
            ST_FINISH: begin
               busy_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
            default: begin
               state_q <= ST_IDLE;
               cyc_q   <= 1'b0;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_abacus_snapshot_reader.sv
// tb/tb_abacus_snapshot_reader.sv - scoreboard bench for the ABACUS snapshot reader
module tb_abacus_snapshot_reader;
   import abacus_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start = 1'b0;
   logic [31:0] base_addr = '0;
   logic [6:0]  word_count = '0;
   logic        busy, done, timeout_err;
   logic        wb_cyc, wb_stb, wb_we;
   logic [31:0] wb_adr, wb_dat_o, wb_dat_i;
   logic        wb_ack;
   logic        m_valid;
   logic        m_ready = 1'b1;
   logic [31:0] m_data;
   logic [5:0]  m_index;
   logic        m_last;

   logic        ack_q = 1'b0;
   logic        ack_en = 1'b1;
   logic        stale = 1'b0;

   typedef struct {
      logic [31:0] data;
      int          idx;
      bit          last;
   } exp_beat_t;

   exp_beat_t   exp_q[$];
   logic [31:0] exp_adr_q[$];

   int n_cmp = 0;
   int n_bad = 0;
   int edge_cnt = 0;
   int done_cnt = 0;
   int done_cyc = 0;
   int cyc_hi = 0;
   int acks = 0;

   abacus_snapshot_reader dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .base_addr  (base_addr),
      .word_count (word_count),
      .busy       (busy),
      .done       (done),
      .timeout_err(timeout_err),
      .wb_cyc     (wb_cyc),
      .wb_stb     (wb_stb),
      .wb_we      (wb_we),
      .wb_adr     (wb_adr),
      .wb_dat_o   (wb_dat_o),
      .wb_dat_i   (wb_dat_i),
      .wb_ack     (wb_ack),
      .m_valid    (m_valid),
      .m_ready    (m_ready),
      .m_data     (m_data),
      .m_index    (m_index),
      .m_last     (m_last)
   );

   always #5 clk = ~clk;

   always @(posedge clk) edge_cnt <= edge_cnt + 1;

   // Registered responder: one-cycle ack, data derived from the address
   always @(posedge clk or negedge rst) begin
      if (!rst) ack_q <= 1'b0;
      else      ack_q <= wb_cyc & wb_stb & ~ack_q & ack_en;
   end
   assign wb_ack   = ack_q | stale;
   assign wb_dat_i = wb_adr ^ 32'hA5A5_A5A5;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic expect_word(input logic [31:0] adr, input logic [31:0] data,
                              input int idx, input bit last);
      exp_beat_t b;
      b.data = data;
      b.idx  = idx;
      b.last = last;
      exp_q.push_back(b);
      exp_adr_q.push_back(adr);
   endtask

   // Stream monitor: every handshake pops and compares one expected beat
   always @(negedge clk) begin
      if (rst && m_valid && m_ready) begin
         check("beat_expected", 32'(exp_q.size() != 0), 32'd1);
         if (exp_q.size() != 0) begin
            exp_beat_t b;
            b = exp_q.pop_front();
            check("beat_data", m_data, b.data);
            check("beat_index", 32'(m_index), 32'(b.idx));
            check("beat_last", 32'(m_last), 32'(b.last));
         end
      end
   end

   // Bus monitor: compares each acknowledged address, counts cycles with cyc high
   always @(negedge clk) begin
      if (wb_cyc) cyc_hi++;
      if (wb_cyc && wb_ack) begin
         acks++;
         check("adr_expected", 32'(exp_adr_q.size() != 0), 32'd1);
         if (exp_adr_q.size() != 0) check("wb_adr", wb_adr, exp_adr_q.pop_front());
      end
      if (done) begin
         done_cnt++;
         done_cyc = edge_cnt + 1;
      end
   end

   task automatic do_start(input logic [31:0] b, input logic [6:0] n, output int k);
      @(negedge clk);
      base_addr  = b;
      word_count = n;
      start      = 1'b1;
      @(posedge clk);
      #1;
      k     = edge_cnt;
      start = 1'b0;
   endtask

   task automatic wait_done(input int budget, input int d0);
      for (int i = 0; i < budget && done_cnt == d0; i++) @(posedge clk);
      check("done_seen", 32'(done_cnt - d0), 32'd1);
      for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(posedge clk);
      check("stream_drained", 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      int k, d0, c0, a0;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst_wb_cyc", 32'(wb_cyc), 0);
      check("rst_wb_stb", 32'(wb_stb), 0);
      check("rst_wb_adr", wb_adr, 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_done", 32'(done), 0);
      check("rst_timeout_err", 32'(timeout_err), 0);
      check("rst_m_valid", 32'(m_valid), 0);
      check("rst_m_data", m_data, 0);
      @(negedge clk);
      rst = 1'b1;

      // Reset asserted mid-REQ clears outputs immediately
      d0 = done_cnt;
      do_start(ABACUS_IPROF_BASE, 7'd3, k);
      check("mid_req_cyc", 32'(wb_cyc), 1);
      rst = 1'b0;
      #1;
      check("arst_wb_cyc", 32'(wb_cyc), 0);
      check("arst_busy", 32'(busy), 0);
      check("arst_done", 32'(done), 0);
      check("arst_m_valid", 32'(m_valid), 0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      repeat (6) @(posedge clk);
      #1;
      check("post_rst_busy", 32'(busy), 0);
      check("post_rst_wb_cyc", 32'(wb_cyc), 0);
      check("post_rst_m_valid", 32'(m_valid), 0);
      check("post_rst_no_done", 32'(done_cnt - d0), 0);

      // Three-word read with an ignored second start mid-burst
      expect_word(32'hF003_0100, 32'h55A6_A4A5, 0, 1'b0);
      expect_word(32'hF003_0104, 32'h55A6_A4A1, 1, 1'b0);
      expect_word(32'hF003_0108, 32'h55A6_A4AD, 2, 1'b1);
      d0 = done_cnt;
      do_start(32'hF003_0100, 7'd3, k);
      check("first_cyc_k1", 32'(wb_cyc), 1);
      check("first_adr_k1", wb_adr, 32'hF003_0100);
      check("busy_k1", 32'(busy), 1);
      repeat (2) @(posedge clk);
      @(negedge clk);
      base_addr  = 32'h1234_5678;
      word_count = 7'd5;
      start      = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      wait_done(60, d0);
      check("three_done_cycle", 32'(done_cyc), 32'(k + 9));
      repeat (10) @(posedge clk);
      #1;
      check("single_done", 32'(done_cnt - d0), 1);
      check("idle_busy", 32'(busy), 0);

      // Backpressure: two words buffered, then held in GAP with the bus idle
      m_ready = 1'b0;
      expect_word(32'hF003_0200, 32'h55A6_A7A5, 0, 1'b0);
      expect_word(32'hF003_0204, 32'h55A6_A7A1, 1, 1'b0);
      expect_word(32'hF003_0208, 32'h55A6_A7AD, 2, 1'b0);
      expect_word(32'hF003_020C, 32'h55A6_A7A9, 3, 1'b1);
      d0 = done_cnt;
      a0 = acks;
      do_start(32'hF003_0200, 7'd4, k);
      repeat (20) @(posedge clk);
      #1;
      check("bp_acks", 32'(acks - a0), 2);
      check("bp_wb_cyc", 32'(wb_cyc), 0);
      check("bp_busy", 32'(busy), 1);
      check("bp_m_valid", 32'(m_valid), 1);
      m_ready = 1'b1;
      wait_done(100, d0);
      check("bp_acks_total", 32'(acks - a0), 4);

      // Timeout: responder silent
      ack_en = 1'b0;
      d0 = done_cnt;
      c0 = cyc_hi;
      do_start(ABACUS_BASE_ADDR, 7'd3, k);
      wait_done(60, d0);
      check("to_cyc_cycles", 32'(cyc_hi - c0), 16);
      check("to_done_cycle", 32'(done_cyc), 32'(k + 17));
      #1;
      check("to_err", 32'(timeout_err), 1);
      repeat (5) @(posedge clk);
      #1;
      check("to_err_sticky", 32'(timeout_err), 1);
      check("to_no_beat", 32'(m_valid), 0);
      ack_en = 1'b1;

      // Zero-length start
      d0 = done_cnt;
      c0 = cyc_hi;
      do_start(32'hF003_0000, 7'd0, k);
      wait_done(10, d0);
      check("zero_done_cycle", 32'(done_cyc), 32'(k + 1));
      check("zero_no_cyc", 32'(cyc_hi - c0), 0);
      check("zero_clears_err", 32'(timeout_err), 0);

      // Address wrap with a stale ack injected during GAP
      expect_word(32'hFFFF_FFFC, 32'h5A5A_5A59, 0, 1'b0);
      expect_word(32'h0000_0000, 32'hA5A5_A5A5, 1, 1'b1);
      d0 = done_cnt;
      do_start(32'hFFFF_FFFF, 7'd2, k);
      check("wrap_first_adr", wb_adr, 32'hFFFF_FFFC);
      repeat (2) @(posedge clk);
      #1;
      stale = 1'b1;
      @(posedge clk);
      #1;
      stale = 1'b0;
      wait_done(30, d0);
      check("wrap_done_cycle", 32'(done_cyc), 32'(k + 6));

      // Oversized count clamps to 64 words
      for (int i = 0; i < 64; i++) begin
         logic [31:0] a;
         a = 32'hF003_0000 + 32'(4 * i);
         expect_word(a, a ^ 32'hA5A5_A5A5, i, i == 63);
      end
      d0 = done_cnt;
      a0 = acks;
      do_start(32'hF003_0000, 7'd100, k);
      wait_done(400, d0);
      check("clamp_acks", 32'(acks - a0), 64);
      check("clamp_done_cycle", 32'(done_cyc), 32'(k + 192));

      repeat (5) @(posedge clk);
      check("adr_queue_empty", 32'(exp_adr_q.size()), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
